data_memory_bank: RTL

- Parametrised successor to the processor's single-port data RAM: byte-addressed, word-organised, byte-enable writes.
- Valid/ready request and response channels with backpressure.
- Explicit error response for out-of-range and misaligned accesses.
- Sits between the LSU/datapath and on-chip data storage; one request accepted per cycle, one response per accepted request.

---
 rtl/data_memory_bank.sv | 117 +++++++++++
 1 files changed

// File: rtl/data_memory_bank.sv
// data_memory_bank: byte-addressed, word-organised data RAM with byte-enable
// writes, valid/ready request and response channels, and an error response
// for misaligned or out-of-range accesses.
// Optional feature: define DMEM_STATS_EN to build the read/write/error
// counters; otherwise the stat ports are tied to zero.
`timescale 1ns/1ps

module data_memory_bank #(
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [31:0]             stat_rd,
    output logic [31:0]             stat_wr,
    output logic [31:0]             stat_err
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFS_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [31:0]      off;
    logic             addr_err;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             rd_ok;
    logic             wr_ok;
    logic             err_acc;

    // The offset is range-checked in full before slicing, so addresses past
    // the end of the bank are rejected rather than wrapping onto low words.
    assign off      = req_addr - BASE_ADDR;
    assign addr_err = (req_addr < BASE_ADDR)
                   || (off[OFS_W-1:0] != '0)
                   || ((off >> OFS_W) >= 32'(DEPTH));
    assign idx      = off[OFS_W+IDX_W-1:OFS_W];

    // Single response register: a new request fits whenever that register is
    // empty or is being drained on this same edge.
    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;
    assign rd_ok     = accept && !req_write && !addr_err;
    assign wr_ok     = accept &&  req_write && !addr_err;
    assign err_acc   = accept &&  addr_err;

    // Storage write port: only enabled bytes of an accepted, error-free write.
    // NOTE: the RAM array has no reset; it sits in its own clocked block so it
    // can map onto a memory macro, and rst gates the write enable explicitly
    // because this block does not see the asynchronous reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response register: load on acceptance, clear when drained, hold otherwise.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_err   <= addr_err;
            resp_rdata <= rd_ok ? mem[idx] : '0;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating access counters, bumped on the acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_err <= '0;
        end else begin
            if (rd_ok && (stat_rd != '1)) begin
                stat_rd <= stat_rd + 32'd1;
            end
            if (wr_ok && (stat_wr != '1)) begin
                stat_wr <= stat_wr + 32'd1;
            end
            if (err_acc && (stat_err != '1)) begin
                stat_err <= stat_err + 32'd1;
            end
        end
    end
`else
    // Counters not built; err_acc only feeds them, so it is folded in here.
    assign stat_rd  = 32'd0;
    assign stat_wr  = 32'd0;
    assign stat_err = {31'd0, err_acc & 1'b0};
`endif

endmodule
